// File: rtl/fetch_inst_queue_pkg.sv
// Shared types and sizing for the fetch instruction queue that sits between
// fetch2 and rename/dispatch.
package fetch_inst_queue_pkg;

    localparam int FETCH_WIDTH    = 4;
    localparam int DISPATCH_WIDTH = 4;
    localparam int DEPTH          = 32;
    localparam int PKT_W          = 64;

    // Pointers carry one extra wrap bit so a full queue is distinguishable from an empty one.
    localparam int FIQ_PTR_W = $clog2(DEPTH) + 1;
    localparam int FIQ_IDX_W = $clog2(DEPTH);
    localparam int WCNT_W    = $clog2(FETCH_WIDTH) + 1;

    typedef logic [PKT_W-1:0]     decode_pkt_t;
    typedef logic [FIQ_PTR_W-1:0] fiq_ptr_t;
    typedef logic [WCNT_W-1:0]    fiq_wcnt_t;

endpackage

// File: rtl/fetch_inst_queue_if.sv
// Packet interface between fetch2 (master side) and the fetch instruction
// queue (slave side), including the dispatch-facing bundle outputs.
interface fetch_inst_queue_if;
    import fetch_inst_queue_pkg::*;

    logic                              flush_i;
    logic [FETCH_WIDTH-1:0]            valid_i;
    logic [FETCH_WIDTH*PKT_W-1:0]      pkt_i;
    logic                              stall_i;
    logic                              full_o;
    logic [DISPATCH_WIDTH-1:0]         valid_o;
    logic [DISPATCH_WIDTH*PKT_W-1:0]   pkt_o;
    fiq_ptr_t                          count_o;

    modport master (
        output flush_i, valid_i, pkt_i, stall_i,
        input  full_o, valid_o, pkt_o, count_o
    );

    modport slave (
        input  flush_i, valid_i, pkt_i, stall_i,
        output full_o, valid_o, pkt_o, count_o
    );

endinterface

// File: rtl/fiq_compact.sv
// Prefix popcount of the fetch lane valids: each valid lane's offset from the
// tail pointer, plus the total number of packets written this cycle.
module fiq_compact
    import fetch_inst_queue_pkg::*;
(
    input  logic [FETCH_WIDTH-1:0] valid_i,
    output fiq_wcnt_t              offset_o [FETCH_WIDTH],
    output fiq_wcnt_t              n_wr_o
);

    fiq_wcnt_t running;

    always_comb begin
        running = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            offset_o[i] = running;
            running     = running + fiq_wcnt_t'(valid_i[i]);
        end
        n_wr_o = running;
    end

endmodule

// File: rtl/fetch_inst_queue.sv
// Circular queue buffering fetch2 decode packets and presenting full
// DISPATCH_WIDTH bundles to dispatch; flushes on recovery or exception.
module fetch_inst_queue
    import fetch_inst_queue_pkg::*;
(
    input logic               clk,
    input logic               reset,
    fetch_inst_queue_if.slave fiq
);

    fiq_ptr_t    head_q, head_d;
    fiq_ptr_t    tail_q, tail_d;
    fiq_ptr_t    count;
    decode_pkt_t mem_q [DEPTH];
    decode_pkt_t mem_d [DEPTH];
    fiq_wcnt_t   wr_off [FETCH_WIDTH];
    fiq_wcnt_t   n_wr;
    logic        full;
    logic        rd_valid;
    logic        wr_en;
    logic        pop;
    logic [FIQ_IDX_W-1:0] wr_idx;
    logic [FIQ_IDX_W-1:0] rd_idx;

    fiq_compact u_compact (
        .valid_i  (fiq.valid_i),
        .offset_o (wr_off),
        .n_wr_o   (n_wr)
    );

    // Status is derived only from registered pointers, never from this cycle's inputs.
    assign count    = tail_q - head_q;
    assign full     = count > fiq_ptr_t'(DEPTH - FETCH_WIDTH);
    assign rd_valid = count >= fiq_ptr_t'(DISPATCH_WIDTH);
    assign wr_en    = !full && !fiq.flush_i;
    assign pop      = rd_valid && !fiq.stall_i;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        mem_d  = mem_q;
        wr_idx = '0;
        if (wr_en) begin
            for (int i = 0; i < FETCH_WIDTH; i++) begin
                wr_idx = FIQ_IDX_W'(tail_q + fiq_ptr_t'(wr_off[i]));
                if (fiq.valid_i[i]) begin
                    mem_d[wr_idx] = fiq.pkt_i[i*PKT_W +: PKT_W];
                end
            end
            tail_d = tail_q + fiq_ptr_t'(n_wr);
        end
        if (pop) begin
            head_d = head_q + fiq_ptr_t'(DISPATCH_WIDTH);
        end
        // Flush wins over any same-cycle write or pop.
        if (fiq.flush_i) begin
            head_d = '0;
            tail_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        fiq.pkt_o = '0;
        rd_idx    = '0;
        for (int j = 0; j < DISPATCH_WIDTH; j++) begin
            rd_idx = FIQ_IDX_W'(head_q + fiq_ptr_t'(j));
            if (rd_valid) begin
                fiq.pkt_o[j*PKT_W +: PKT_W] = mem_q[rd_idx];
            end
        end
    end

    assign fiq.valid_o = {DISPATCH_WIDTH{rd_valid}};
    assign fiq.full_o  = full;
    assign fiq.count_o = count;

    // Fetch2 must hold while full; anything offered anyway is dropped.
    a_no_write_when_full: assert property (
        @(posedge clk) disable iff (!reset) !(full && (|fiq.valid_i))
    ) else $warning("fetch_inst_queue: packets offered while full_o=1 were dropped");

endmodule
